// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// ---------------
// This module is a generic pipeline-stage register with a valid/ready handshake and
// a 2-entry skid buffer. The main register drives the outputs. The skid register
// catches the word that is accepted in the cycle the downstream stalls. Because
// in_ready depends only on a flop (skid occupancy), it never depends
// combinationally on out_ready.
//
// Parameters:
//   WIDTH     - payload width in bits (>= 1)
//   NOP_VALUE - bubble driven on out_data whenever out_valid = 0
//
// Ports:
//   clock     - single clock; all state changes on its rising edge
//   rst_n     - synchronous active-low reset; overrides flush and handshakes
//   flush     - synchronous discard of every held entry
//   in_valid  - upstream offers in_data this cycle
//   in_data   - upstream payload
//   in_ready  - stage can accept (low only while the skid entry is occupied)
//   out_valid - out_data holds a live entry
//   out_data  - head entry, NOP_VALUE when out_valid = 0
//   out_ready - downstream consumes the head entry this cycle
//
// Optional build macro PIPE_STAGE_STATS_EN adds two outputs:
//   stall_cnt - saturating count of cycles with out_valid & !out_ready
//   flush_cnt - saturating count of cycles with flush = 1 outside reset
// Reset clears both counters. Flush does not clear them.

module pipe_stage_skid #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  // The encoding is {skid_v, main_v}, so each occupancy bit can be read
  // directly from the state. The value 2'b10 is never entered.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t           state_q;
  state_t           state_next;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] main_data_next;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_data_next;
  logic             accept;
  logic             consume;

  assign out_valid = state_q[0];
  assign out_data  = main_data;
  assign in_ready  = ~state_q[1];

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    state_next     = state_q;
    main_data_next = main_data;
    skid_data_next = skid_data;

    if (flush) begin
      // A word accepted in the flush cycle is dropped along with the held entries.
      state_next     = EMPTY;
      main_data_next = NOP_VALUE;
      skid_data_next = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_next     = ONE;
            main_data_next = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_data_next = in_data;
          end else if (consume) begin
            state_next     = EMPTY;
            main_data_next = NOP_VALUE;
          end else if (accept) begin
            state_next     = FULL;
            skid_data_next = in_data;
          end
        end
        FULL: begin
          // in_ready is low here, so only a consume can move the state.
          // While stalled, main_data holds its value.
          if (consume) begin
            state_next     = ONE;
            main_data_next = skid_data;
            skid_data_next = NOP_VALUE;
          end
        end
        default: begin
          // The unreachable encoding recovers to a clean empty stage.
          state_next     = EMPTY;
          main_data_next = NOP_VALUE;
          skid_data_next = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_data <= NOP_VALUE;
      skid_data <= NOP_VALUE;
    end else begin
      state_q   <= state_next;
      main_data <= main_data_next;
      skid_data <= skid_data_next;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Both counters saturate instead of wrapping, so a long stall never reads as a short one.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'h0001;
      end
      if (flush && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// ------------------
// This is the testbench for pipe_stage_skid with WIDTH = 64 and NOP_VALUE = 0.
// It has four parts:
//   - A table of per-cycle vectors. Each vector holds the inputs applied before
//     a clock edge and the outputs expected after that edge.
//   - A hand-written streaming sequence.
//   - A randomized run checked against a queue model. The model treats the stage
//     as a FIFO of depth 2, so in_ready is (count < 2) and the head of the queue
//     is out_data.
//   - Counter checks, included only when PIPE_STAGE_STATS_EN is defined.

module tb_pipe_stage_skid;

  localparam int WIDTH = 64;

  logic             clock;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stage_skid #(
    .WIDTH(WIDTH),
    .NOP_VALUE({WIDTH{1'b0}})
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_ready;
    logic        exp_valid;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic r, input logic f, input logic iv,
                              input logic [63:0] d, input logic orr,
                              input logic er, input logic ev, input logic [63:0] ed);
    vec_t v;
    v.rst_n = r; v.flush = f; v.in_valid = iv; v.in_data = d; v.out_ready = orr;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs are driven 1 time unit after the edge. The outputs are then read at the
  // same point in the following cycle, well away from the active edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic iv,
                               input logic [63:0] d, input logic orr);
    rst_n     = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = orr;
    cycle();
  endtask

  initial begin
    logic [63:0] model_q[$];
    logic        hold;
    logic        acc;
    logic        con;
    int          cycles;
    int          consumed;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //               rst flush iv  data      ordy   ir    ov    data
    vecs[0]  = mk(1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'h0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0, 64'h0);
    vecs[2]  = mk(1'b1, 1'b0, 1'b1, 64'h1,    1'b1, 1'b1, 1'b1, 64'h1);
    vecs[3]  = mk(1'b1, 1'b0, 1'b1, 64'h2,    1'b1, 1'b1, 1'b1, 64'h2);
    vecs[4]  = mk(1'b1, 1'b0, 1'b1, 64'h3,    1'b1, 1'b1, 1'b1, 64'h3);
    vecs[5]  = mk(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0);
    vecs[6]  = mk(1'b1, 1'b0, 1'b1, 64'hA,    1'b1, 1'b1, 1'b1, 64'hA);
    vecs[7]  = mk(1'b1, 1'b0, 1'b1, 64'hB,    1'b0, 1'b0, 1'b1, 64'hA);
    vecs[8]  = mk(1'b1, 1'b0, 1'b1, 64'hC,    1'b0, 1'b0, 1'b1, 64'hA);
    vecs[9]  = mk(1'b1, 1'b0, 1'b1, 64'hC,    1'b1, 1'b1, 1'b1, 64'hB);
    vecs[10] = mk(1'b1, 1'b0, 1'b1, 64'hC,    1'b1, 1'b1, 1'b1, 64'hC);
    vecs[11] = mk(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0);
    vecs[12] = mk(1'b1, 1'b0, 1'b1, 64'hA,    1'b0, 1'b1, 1'b1, 64'hA);
    vecs[13] = mk(1'b1, 1'b0, 1'b1, 64'hB,    1'b0, 1'b0, 1'b1, 64'hA);
    vecs[14] = mk(1'b1, 1'b1, 1'b1, 64'hC,    1'b0, 1'b1, 1'b0, 64'h0);
    vecs[15] = mk(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0);
    vecs[16] = mk(1'b1, 1'b0, 1'b1, 64'hA,    1'b0, 1'b1, 1'b1, 64'hA);
    vecs[17] = mk(1'b1, 1'b0, 1'b1, 64'hB,    1'b0, 1'b0, 1'b1, 64'hA);
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 64'hC,    1'b0, 1'b1, 1'b0, 64'h0);
    vecs[19] = mk(1'b1, 1'b0, 1'b0, 64'h0,    1'b1, 1'b1, 1'b0, 64'h0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid,
                    vecs[i].in_data, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d_in_ready", i), {63'b0, in_ready}, {63'b0, vecs[i].exp_ready});
      checkOutput($sformatf("vec%0d_out_valid", i), {63'b0, out_valid}, {63'b0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_data);
    end

    // Streaming: eight back-to-back words, each visible 1 cycle after acceptance.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 64'(k), 1'b1);
      checkOutput($sformatf("stream%0d_data", k), out_data, 64'(k));
      checkOutput($sformatf("stream%0d_valid", k), {63'b0, out_valid}, 64'd1);
      checkOutput($sformatf("stream%0d_ready", k), {63'b0, in_ready}, 64'd1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("stream_drain_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("stream_drain_data", out_data, 64'h0);

`ifdef PIPE_STAGE_STATS_EN
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("stats_reset_stall", {48'b0, stall_cnt}, 64'd0);
    checkOutput("stats_reset_flush", {48'b0, flush_cnt}, 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("stats_flush3", {48'b0, flush_cnt}, 64'd3);
    checkOutput("stats_flush3_stall", {48'b0, stall_cnt}, 64'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 64'h55, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) cycle();
    checkOutput("stats_stall_sat", {48'b0, stall_cnt}, 64'hFFFF);
    checkOutput("stats_flush_kept", {48'b0, flush_cnt}, 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("stats_clear_stall", {48'b0, stall_cnt}, 64'd0);
    checkOutput("stats_clear_flush", {48'b0, flush_cnt}, 64'd0);
`endif

    // Randomized run. The model is a queue holding at most 2 entries.
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
    rst_n    = 1'b1;
    hold     = 1'b0;
    cycles   = 0;
    consumed = 0;
    while (consumed < 10000 && cycles < 60000) begin
      checkOutput("rnd_in_ready", {63'b0, in_ready}, {63'b0, model_q.size() < 2});
      checkOutput("rnd_out_valid", {63'b0, out_valid}, {63'b0, model_q.size() > 0});
      checkOutput("rnd_out_data", out_data, (model_q.size() > 0) ? model_q[0] : 64'h0);
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = {$urandom, $urandom};
      end
      out_ready = 1'($urandom_range(0, 1));
      acc = in_valid && (model_q.size() < 2);
      con = (model_q.size() > 0) && out_ready;
      if (con) begin
        void'(model_q.pop_front());
        consumed++;
      end
      if (acc) model_q.push_back(in_data);
      hold = in_valid && !acc;
      cycle();
      cycles++;
    end
    checkOutput("rnd_word_count", 64'(consumed), 64'd10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed 32-bit IF/ID latch: a generic pipeline-stage register carrying a WIDTH-bit payload between any two stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never drops or duplicates a word and in_ready is fully registered.
- Supports synchronous flush and a parametrised bubble value (NOP) driven whenever the stage is empty.
- First use is IF→ID with payload {PC_Plus4, Inst} (WIDTH=64); ID/EX and EX/MEM reuse it.

Parameters:
WIDTH, 64, payload width in bits (≥1).
NOP_VALUE, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0 (reset, flush, drained).

Ports:
clock  in  1  single clock, all state on posedge.
rst_n  in  1  synchronous, active-low reset; sampled on posedge clock only.
flush  in  1  synchronous discard of all held entries (branch/jump redirect).
in_valid  in  1  upstream offers in_data this cycle.
in_data  in  WIDTH  upstream payload.
in_ready  out  1  stage can accept; registered, not combinationally dependent on out_ready.
out_valid  out  1  out_data holds a live entry.
out_data  out  WIDTH  head entry; NOP_VALUE when out_valid=0.
out_ready  in  1  downstream consumes head this cycle (replaces IFIDWrite as stall control).

Behaviour:
- Storage: main register (main_v, main_d) drives outputs; skid register (skid_v, skid_d) catches the word accepted in the cycle the downstream stalls.
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- in_ready = !skid_v, registered. out_valid = main_v. out_data = main_d.
- Reset (rst_n=0 at posedge): main_v=0, skid_v=0, main_d=NOP_VALUE, skid_d=NOP_VALUE. Next cycle: in_ready=1, out_valid=0, out_data=NOP_VALUE. Reset overrides flush and all handshakes. In-flight words are discarded; mid-stall reset is legal.
- States, encoded as {skid_v, main_v}:
  - EMPTY (00): Accept → ONE, main_d=in_data.
  - ONE (01):
    - Accept & Consume → ONE, main_d=in_data.
    - Consume only → EMPTY, main_d=NOP_VALUE.
    - Accept only → FULL, skid_d=in_data.
    - Neither → hold.
  - FULL (11), in_ready=0:
    - Consume → ONE, main_d=skid_d, skid_d=NOP_VALUE.
    - Else → hold; main_d stays stable while stalled.
  - State 10 is illegal and unreachable.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1 word/cycle with out_ready held high.
- Ordering is strict FIFO. No word is lost or duplicated under any out_ready pattern.
- Flush (rst_n=1, flush=1): next state EMPTY, both data registers = NOP_VALUE. Priority over accept and consume; a word accepted in the flush cycle is discarded. in_ready=1 the cycle after flush.
- The upstream must hold in_valid/in_data while in_ready=0 (standard valid/ready rule). The block does not check this.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] (cycles with out_valid & !out_ready) and flush_cnt[15:0] (cycles with flush=1 and rst_n=1).
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset and are not cleared by flush.
- Undefined: the ports and counters do not exist; handshake behaviour is identical.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_data=64'hDEAD → out_valid=0, out_data=0, in_ready=1 the first cycle after rst_n=1.
- Streaming: out_ready=1, feed 0x1..0x8 back-to-back → out_data 0x1..0x8 on 8 consecutive cycles, each 1 cycle after accept, in_ready stays 1.
- Stall/skid: out_ready=0 after 0xA accepted, offer 0xB, 0xC → 0xB taken, in_ready=0, 0xC held upstream. Then out_ready=1 → outputs 0xA, 0xB, 0xC in order, with no gaps after release.
- Flush while FULL (0xA main, 0xB skid), flush=1 with in_valid=1 and 0xC offered → next cycle out_valid=0, out_data=NOP_VALUE, in_ready=1; 0xC never appears.
- Reset mid-stall in FULL with flush=1 simultaneously → reset wins; state EMPTY. With PIPE_STAGE_STATS_EN: stall_cnt=0 and flush_cnt=0 after reset; 70000 stall cycles → stall_cnt=16'hFFFF.
- Random: random in_valid/out_ready at 50% each, 10k words, against a scoreboard queue → exact in-order match, zero loss or duplication.
